// File: rtl/hilo_sequencer.sv
// HI/LO sequencer for the multicycle divider/multiplier: runs one op for a fixed
// cycle count, then captures the unit's results into the architectural HI/LO.
module hilo_sequencer #(
    parameter int DIV_CYCLES  = 34,
    parameter int MULT_CYCLES = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_start,
    input  logic        op_sel,
    input  logic [31:0] div_hi_in,
    input  logic [31:0] div_lo_in,
    input  logic        div_zero_in,
    input  logic [31:0] mult_hi_in,
    input  logic [31:0] mult_lo_in,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] wdata,
    output logic        div_control,
    output logic        mult_control,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy,
    output logic        done,
    output logic        div_zero_exc
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DIV_RUN,
        MULT_RUN,
        CAPTURE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          op_is_mult;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            op_is_mult   <= 1'b0;
            div_control  <= 1'b0;
            mult_control <= 1'b0;
            hi_out       <= '0;
            lo_out       <= '0;
            done         <= 1'b0;
            div_zero_exc <= 1'b0;
        end else begin
            // Status pulses last exactly one cycle; only CAPTURE raises them.
            done         <= 1'b0;
            div_zero_exc <= 1'b0;
            case (state)
                IDLE: begin
                    if (mthi_we) hi_out <= wdata;
                    if (mtlo_we) lo_out <= wdata;
                    if (op_start) begin
                        op_is_mult <= op_sel;
                        if (op_sel) begin
                            state        <= MULT_RUN;
                            cnt          <= CW'(MULT_CYCLES - 1);
                            mult_control <= 1'b1;
                        end else begin
                            state       <= DIV_RUN;
                            cnt         <= CW'(DIV_CYCLES - 1);
                            div_control <= 1'b1;
                        end
                    end
                end
                DIV_RUN, MULT_RUN: begin
                    if (cnt == '0) begin
                        div_control  <= 1'b0;
                        mult_control <= 1'b0;
                        state        <= CAPTURE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    state <= IDLE;
                    done  <= 1'b1;
                    if (op_is_mult) begin
                        hi_out <= mult_hi_in;
                        lo_out <= mult_lo_in;
                    end else if (div_zero_in) begin
                        div_zero_exc <= 1'b1;
                    end else begin
                        hi_out <= div_hi_in;
                        lo_out <= div_lo_in;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_sequencer.sv
// Directed bench for hilo_sequencer: cycle counts, capture, exceptions, ignored
// requests while busy, back-to-back start and asynchronous reset.
module tb_hilo_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_start, op_sel;
    logic [31:0] div_hi_in, div_lo_in, mult_hi_in, mult_lo_in, wdata;
    logic        div_zero_in, mthi_we, mtlo_we;
    logic        div_control, mult_control, busy, done, div_zero_exc;
    logic [31:0] hi_out, lo_out;

    int n_checks = 0;
    int n_pass   = 0;

    hilo_sequencer #(.DIV_CYCLES(34), .MULT_CYCLES(33)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_start     (op_start),
        .op_sel       (op_sel),
        .div_hi_in    (div_hi_in),
        .div_lo_in    (div_lo_in),
        .div_zero_in  (div_zero_in),
        .mult_hi_in   (mult_hi_in),
        .mult_lo_in   (mult_lo_in),
        .mthi_we      (mthi_we),
        .mtlo_we      (mtlo_we),
        .wdata        (wdata),
        .div_control  (div_control),
        .mult_control (mult_control),
        .hi_out       (hi_out),
        .lo_out       (lo_out),
        .busy         (busy),
        .done         (done),
        .div_zero_exc (div_zero_exc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the sample point just after the accepting edge E0.
    task automatic start_op(input logic sel);
        tick();
        op_start = 1'b1;
        op_sel   = sel;
        tick();
        op_start = 1'b0;
    endtask

    // Samples once per cycle from E0 until busy drops; optionally injects
    // op_start(MULT)+mthi during the run at sample index inject_at.
    task automatic measure(input int inject_at, output int div_n, output int mult_n,
                           output int busy_n, output int early_done, output int hi_moved);
        int k;
        logic [31:0] hi0;
        hi0 = hi_out;
        div_n = 0; mult_n = 0; busy_n = 0; early_done = 0; hi_moved = 0; k = 0;
        while (busy && k < 200) begin
            if (div_control)  div_n++;
            if (mult_control) mult_n++;
            if (done)         early_done++;
            if (hi_out !== hi0) hi_moved++;
            busy_n++;
            if (k == inject_at) begin
                op_start = 1'b1; op_sel = 1'b1; mthi_we = 1'b1; wdata = 32'h1234;
            end else begin
                op_start = 1'b0; mthi_we = 1'b0;
            end
            tick();
            k++;
        end
        op_start = 1'b0;
        mthi_we  = 1'b0;
        check("run_bounded", {31'b0, busy}, 32'd0);
    endtask

    int dn, mn, bn, ed, hm;

    initial begin
        reset = 1'b1; op_start = 0; op_sel = 0; mthi_we = 0; mtlo_we = 0; wdata = '0;
        div_hi_in = '0; div_lo_in = '0; div_zero_in = 0; mult_hi_in = '0; mult_lo_in = '0;
        tick(); tick();
        check("rst_hi", hi_out, 0);
        check("rst_lo", lo_out, 0);
        check("rst_ctl", {30'b0, div_control, mult_control}, 0);
        check("rst_flags", {29'b0, busy, done, div_zero_exc}, 0);
        reset = 1'b0;

        // Reset mid-idle clears HI without a clock edge
        mthi_we = 1'b1; wdata = 32'h77;
        tick();
        mthi_we = 1'b0;
        check("mthi_idle", hi_out, 32'h77);
        #2 reset = 1'b1;
        #1 check("rst_idle_hi", hi_out, 0);
        #2 reset = 1'b0;

        // Plain DIV
        div_hi_in = 32'd1; div_lo_in = 32'd3; div_zero_in = 1'b0;
        start_op(1'b0);
        measure(-1, dn, mn, bn, ed, hm);
        check("div_ctl_cycles", dn, 34);
        check("div_busy_cycles", bn, 35);
        check("div_mult_ctl", mn, 0);
        check("div_no_early_done", ed, 0);
        check("div_done", {31'b0, done}, 1);
        check("div_exc", {31'b0, div_zero_exc}, 0);
        check("div_hi", hi_out, 1);
        check("div_lo", lo_out, 3);
        tick();
        check("div_done_pulse", {31'b0, done}, 0);

        // DIV by zero keeps HI/LO from mthi/mtlo
        mthi_we = 1'b1; wdata = 32'hAAAA;
        tick();
        mthi_we = 1'b0; mtlo_we = 1'b1; wdata = 32'h5555;
        tick();
        mtlo_we = 1'b0;
        div_hi_in = 32'hDEAD; div_lo_in = 32'hBEEF; div_zero_in = 1'b1;
        start_op(1'b0);
        measure(-1, dn, mn, bn, ed, hm);
        check("dz_done", {31'b0, done}, 1);
        check("dz_exc", {31'b0, div_zero_exc}, 1);
        check("dz_hi", hi_out, 32'hAAAA);
        check("dz_lo", lo_out, 32'h5555);
        tick();
        check("dz_pulse", {30'b0, done, div_zero_exc}, 0);
        div_zero_in = 1'b0;

        // MULT
        mult_hi_in = 32'hFFFF_FFFF; mult_lo_in = 32'hFFFF_FFFE;
        start_op(1'b1);
        measure(-1, dn, mn, bn, ed, hm);
        check("mul_ctl_cycles", mn, 33);
        check("mul_busy_cycles", bn, 34);
        check("mul_div_ctl", dn, 0);
        check("mul_done", {31'b0, done}, 1);
        check("mul_hi", hi_out, 32'hFFFF_FFFF);
        check("mul_lo", lo_out, 32'hFFFF_FFFE);

        // Requests during DIV_RUN ignored; back-to-back DIV from the done cycle
        div_hi_in = 32'h11; div_lo_in = 32'h22;
        start_op(1'b0);
        measure(5, dn, mn, bn, ed, hm);
        check("ign_mult_ctl", mn, 0);
        check("ign_busy_cycles", bn, 35);
        check("ign_hi_stable", hm, 0);
        check("ign_done", {31'b0, done}, 1);
        check("ign_hi", hi_out, 32'h11);
        div_hi_in = 32'h33; div_lo_in = 32'h44;
        op_start = 1'b1; op_sel = 1'b0;
        tick();
        op_start = 1'b0;
        check("b2b_busy", {31'b0, busy}, 1);
        check("b2b_ctl", {31'b0, div_control}, 1);
        measure(-1, dn, mn, bn, ed, hm);
        check("b2b_ctl_cycles", dn, 34);
        check("b2b_hi", hi_out, 32'h33);
        check("b2b_lo", lo_out, 32'h44);

        // Async reset at cycle 10 of DIV_RUN
        start_op(1'b0);
        repeat (9) tick();
        check("pre_rst_ctl", {31'b0, div_control}, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_ctl", {31'b0, div_control}, 0);
        check("mid_rst_busy", {31'b0, busy}, 0);
        check("mid_rst_hilo", hi_out | lo_out, 0);
        check("mid_rst_done", {31'b0, done}, 0);
        #2 reset = 1'b0;
        tick();
        check("post_rst_done", {31'b0, done}, 0);
        mult_hi_in = 32'h0BAD; mult_lo_in = 32'hF00D;
        start_op(1'b1);
        measure(-1, dn, mn, bn, ed, hm);
        check("post_rst_mul_cycles", mn, 33);
        check("post_rst_hi", hi_out, 32'h0BAD);
        check("post_rst_lo", lo_out, 32'hF00D);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
